fust_table: RTL

- Parametrised functional-unit status table (scoreboard) for the scalar and matrix issue paths.
- Generalises the fixed 2-source scalar and 3-source matrix status rows into one block parametrised in FU count, register-index width and source count.
- Adds register-result tracking and dependency wakeup that the plain row structs lack.
- Adds RAW/WAW/WAR hazard resolution, placing the block between dispatch and the FUs.

---
 rtl/fust_table_if.sv | 35 +++
 rtl/fust_table.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fust_table_if.sv
// Dispatch / FU side bus of the functional-unit status table.
// The table takes the slave side; dispatch logic or a bench takes the master side.
interface fust_table_if #(
   parameter int unsigned NUM_FU  = 4,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned FU_W    = $clog2(NUM_FU),
   parameter int unsigned OCC_W   = $clog2(NUM_FU + 1)
);
   logic                     issue_valid;
   logic [FU_W-1:0]          issue_fu;
   logic [REG_W-1:0]         issue_rd;
   logic [NUM_SRC*REG_W-1:0] issue_rs;
   logic                     issue_ready;
   logic                     rd_ack_valid;
   logic [FU_W-1:0]          rd_ack_fu;
   logic                     wb_valid;
   logic [FU_W-1:0]          wb_fu;
   logic [NUM_FU-1:0]        fu_busy;
   logic [NUM_FU-1:0]        fu_ops_ready;
   logic [NUM_FU-1:0]        fu_wb_allow;
   logic [OCC_W-1:0]         occupancy;

   modport master (
      output issue_valid, issue_fu, issue_rd, issue_rs, rd_ack_valid, rd_ack_fu,
             wb_valid, wb_fu,
      input  issue_ready, fu_busy, fu_ops_ready, fu_wb_allow, occupancy
   );

   modport slave (
      input  issue_valid, issue_fu, issue_rd, issue_rs, rd_ack_valid, rd_ack_fu,
             wb_valid, wb_fu,
      output issue_ready, fu_busy, fu_ops_ready, fu_wb_allow, occupancy
   );
endinterface

// File: rtl/fust_table.sv
// Functional-unit status table: per-FU row tracking, register result status,
// wakeup on writeback and RAW/WAW/WAR hazard resolution between dispatch and the FUs.
module fust_table #(
   parameter int unsigned NUM_FU  = 4,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned FU_W    = $clog2(NUM_FU),
   parameter int unsigned OCC_W   = $clog2(NUM_FU + 1)
) (
   input logic         CLK,
   input logic         RST,
   fust_table_if.slave bus
);
   localparam int unsigned NREG = 2 ** REG_W;

   typedef enum logic [1:0] {StIdle, StWait, StReady, StExec} row_st_e;

   row_st_e            state_q [NUM_FU];
   logic [REG_W-1:0]   rd_q    [NUM_FU];
   logic [REG_W-1:0]   rs_q    [NUM_FU][NUM_SRC];
   logic [FU_W-1:0]    tag_q   [NUM_FU][NUM_SRC];
   logic [NUM_SRC-1:0] rdy_q   [NUM_FU];
   logic               res_pend_q [NREG];
   logic [FU_W-1:0]    res_fu_q   [NREG];
   logic [OCC_W-1:0]   occ_q;

   logic [NUM_FU-1:0]  busy, read, busy_nxt;
   logic [NUM_SRC-1:0] rdy_nxt [NUM_FU];
   logic [NUM_SRC-1:0] new_rdy;
   logic [REG_W-1:0]   new_rs  [NUM_SRC];
   logic [FU_W-1:0]    new_tag [NUM_SRC];
   logic               accept, wb_hit, ack_hit;
   logic [OCC_W-1:0]   occ_nxt;

   always_comb begin
      busy     = '0;
      read     = '0;
      busy_nxt = '0;
      occ_nxt  = '0;
      new_rdy  = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         busy[i] = (state_q[i] != StIdle);
         read[i] = (state_q[i] == StExec);
      end
      // Ready decision uses pre-writeback state only: WAW on pending rd, structural on busy FU.
      bus.issue_ready = !busy[bus.issue_fu] &&
                        !((bus.issue_rd != '0) && res_pend_q[bus.issue_rd]);
      accept  = bus.issue_valid && bus.issue_ready;
      wb_hit  = bus.wb_valid && (state_q[bus.wb_fu] == StExec);
      ack_hit = bus.rd_ack_valid && (state_q[bus.rd_ack_fu] == StReady);

      for (int k = 0; k < NUM_SRC; k++) begin
         new_rs[k]  = bus.issue_rs[k*REG_W +: REG_W];
         new_tag[k] = res_fu_q[new_rs[k]];
         // A producer completing this very cycle counts as already available.
         new_rdy[k] = (new_rs[k] == '0) || !res_pend_q[new_rs[k]] ||
                      (wb_hit && (new_tag[k] == bus.wb_fu));
      end

      for (int i = 0; i < NUM_FU; i++) begin
         rdy_nxt[i] = rdy_q[i];
         for (int k = 0; k < NUM_SRC; k++) begin
            if (wb_hit && busy[i] && !rdy_q[i][k] && (tag_q[i][k] == bus.wb_fu)) begin
               rdy_nxt[i][k] = 1'b1;
            end
         end
         if (accept && (bus.issue_fu == FU_W'(i))) begin
            busy_nxt[i] = 1'b1;
         end else if (wb_hit && (bus.wb_fu == FU_W'(i))) begin
            busy_nxt[i] = 1'b0;
         end else begin
            busy_nxt[i] = busy[i];
         end
         occ_nxt = occ_nxt + OCC_W'(busy_nxt[i]);
      end

      bus.fu_busy     = busy;
      bus.occupancy   = occ_q;
      bus.fu_wb_allow = '1;
      for (int i = 0; i < NUM_FU; i++) begin
         bus.fu_ops_ready[i] = busy[i] && (&rdy_q[i]) && !read[i];
         // WAR: another row still has to read the old value of our destination.
         for (int j = 0; j < NUM_FU; j++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
               if ((j != i) && busy[j] && !read[j] && rdy_q[j][k] &&
                   (rs_q[j][k] == rd_q[i])) begin
                  bus.fu_wb_allow[i] = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_FU; i++) begin
            state_q[i] <= StIdle;
            rd_q[i]    <= '0;
            rdy_q[i]   <= '0;
            for (int k = 0; k < NUM_SRC; k++) begin
               rs_q[i][k]  <= '0;
               tag_q[i][k] <= '0;
            end
         end
         for (int r = 0; r < NREG; r++) begin
            res_pend_q[r] <= 1'b0;
            res_fu_q[r]   <= '0;
         end
         occ_q <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            unique case (state_q[i])
               StIdle: begin
                  if (accept && (bus.issue_fu == FU_W'(i))) begin
                     rd_q[i]    <= bus.issue_rd;
                     rdy_q[i]   <= new_rdy;
                     state_q[i] <= (&new_rdy) ? StReady : StWait;
                     for (int k = 0; k < NUM_SRC; k++) begin
                        rs_q[i][k]  <= new_rs[k];
                        tag_q[i][k] <= new_tag[k];
                     end
                  end
               end
               StWait: begin
                  rdy_q[i] <= rdy_nxt[i];
                  if (&rdy_nxt[i]) state_q[i] <= StReady;
               end
               StReady: begin
                  if (ack_hit && (bus.rd_ack_fu == FU_W'(i))) state_q[i] <= StExec;
               end
               StExec: begin
                  if (wb_hit && (bus.wb_fu == FU_W'(i))) begin
                     state_q[i] <= StIdle;
                     rd_q[i]    <= '0;
                     rdy_q[i]   <= '0;
                     for (int k = 0; k < NUM_SRC; k++) begin
                        rs_q[i][k]  <= '0;
                        tag_q[i][k] <= '0;
                     end
                  end
               end
            endcase
         end
         if (wb_hit && (res_fu_q[rd_q[bus.wb_fu]] == bus.wb_fu)) begin
            res_pend_q[rd_q[bus.wb_fu]] <= 1'b0;
         end
         // Later assignment wins: a same-cycle issue to the register overrides the clear.
         if (accept && (bus.issue_rd != '0)) begin
            res_pend_q[bus.issue_rd] <= 1'b1;
            res_fu_q[bus.issue_rd]   <= bus.issue_fu;
         end
         occ_q <= occ_nxt;
      end
   end
endmodule
